// File: rtl/led_pwm_ctrl.sv
// Memory-mapped RGB LED PWM controller with a prescaled 8-bit PWM and an optional blink cycle.
// Four word registers live at BASE_ADDR+0/4/8/C on a shared tri-state data bus.
module led_pwm_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'hffff0010,
  parameter int          PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ON   = 2'b01,
    S_OFF  = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           ctrl_q;
  logic [PRESC_W-1:0]   presc_q;
  logic [23:0]          duty_q;
  logic [15:0]          on_t_q;
  logic [7:0]           off_t_q;
  logic [23:0]          shadow_q, shadow_d;
  logic [PRESC_W-1:0]   pc_q, pc_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [15:0]          per_q, per_d;
  logic                 led_r_d, led_g_d, led_b_d;
  logic [31:0]          rd_data;

  logic hit_ctrl, hit_presc, hit_duty, hit_blink, hit_any;
  logic wr_ctrl, wr_presc, wr_duty, wr_blink;
  logic tick, period_end, en, blink_en;

  assign hit_ctrl  = (mem_addr == BASE_ADDR);
  assign hit_presc = (mem_addr == BASE_ADDR + 32'd4);
  assign hit_duty  = (mem_addr == BASE_ADDR + 32'd8);
  assign hit_blink = (mem_addr == BASE_ADDR + 32'd12);
  assign hit_any   = hit_ctrl | hit_presc | hit_duty | hit_blink;

  assign wr_ctrl  = mem_we & hit_ctrl;
  assign wr_presc = mem_we & hit_presc;
  assign wr_duty  = mem_we & hit_duty;
  assign wr_blink = mem_we & hit_blink;

  assign en       = ctrl_q[0];
  assign blink_en = ctrl_q[1];

  always_comb begin
    rd_data = 32'h0;
    if (hit_ctrl) begin
      rd_data[1:0] = ctrl_q;
      rd_data[9:8] = state_q;
    end else if (hit_presc) begin
      rd_data[PRESC_W-1:0] = presc_q;
    end else if (hit_duty) begin
      rd_data[23:0] = duty_q;
    end else if (hit_blink) begin
      rd_data = {on_t_q, 8'h00, off_t_q};
    end
  end

  // Only drive the bus for a matched read outside reset.
  assign mem_data = (rst && !mem_we && hit_any) ? rd_data : 32'bz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= 2'b00;
      presc_q <= '0;
      duty_q  <= 24'h0;
      on_t_q  <= 16'h0;
      off_t_q <= 8'h0;
    end else begin
      if (wr_ctrl)  ctrl_q  <= mem_data[1:0];
      if (wr_presc) presc_q <= mem_data[PRESC_W-1:0];
      if (wr_duty)  duty_q  <= mem_data[23:0];
      if (wr_blink) begin
        on_t_q  <= mem_data[31:16];
        off_t_q <= mem_data[7:0];
      end
    end
  end

  assign tick       = (state_q != S_IDLE) && (pc_q == presc_q);
  assign period_end = tick && (cnt_q == 8'hff);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // A CTRL write freezes the FSM for that cycle; the new value acts next clock.
  always_comb begin
    state_d = state_q;
    if (!wr_ctrl) begin
      case (state_q)
        S_IDLE: if (en) state_d = S_ON;
        S_ON: begin
          if (!en) state_d = S_IDLE;
          else if (blink_en && period_end && (per_q == on_t_q)) state_d = S_OFF;
        end
        S_OFF: begin
          if (!en) state_d = S_IDLE;
          else if (period_end && (!blink_en || (per_q == {8'h00, off_t_q}))) state_d = S_ON;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    led_r_d = (state_q == S_ON) && (cnt_q < shadow_q[23:16]);
    led_g_d = (state_q == S_ON) && (cnt_q < shadow_q[15:8]);
    led_b_d = (state_q == S_ON) && (cnt_q < shadow_q[7:0]);
  end

  always_comb begin
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    shadow_d = shadow_q;
    if ((state_q == S_IDLE && state_d == S_ON) || period_end) shadow_d = duty_q;
    if (state_d == S_IDLE || state_q == S_IDLE) begin
      pc_d  = '0;
      cnt_d = 8'h00;
      per_d = 16'h0;
    end else begin
      pc_d = tick ? '0 : pc_q + 1'b1;
      if (wr_presc) pc_d = '0;
      if (tick) cnt_d = cnt_q + 8'd1;
      if (period_end) per_d = (state_d != state_q) ? 16'h0 : per_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      cnt_q    <= 8'h00;
      per_q    <= 16'h0;
      shadow_q <= 24'h0;
      led_r    <= 1'b0;
      led_g    <= 1'b0;
      led_b    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      shadow_q <= shadow_d;
      led_r    <= led_r_d;
      led_g    <= led_g_d;
      led_b    <= led_b_d;
    end
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl: register access, PWM duty, blink timing, disable and async reset.
// The bus has weak pull-ups, so an undriven (high-Z) mem_data reads as all ones.
module tb_led_pwm_ctrl;

  localparam logic [31:0] A_CTRL  = 32'hffff0010;
  localparam logic [31:0] A_PRESC = 32'hffff0014;
  localparam logic [31:0] A_DUTY  = 32'hffff0018;
  localparam logic [31:0] A_BLINK = 32'hffff001c;
  localparam logic [31:0] BUS_Z   = 32'hffffffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] tb_wdata = 32'h0;
  logic        tb_oe = 1'b0;
  wire  [31:0] mem_data;
  wire         led_r, led_g, led_b;

  int n_checks = 0;
  int n_fail   = 0;

  assign mem_data = tb_oe ? tb_wdata : 32'bz;

  for (genvar gi = 0; gi < 32; gi++) begin : g_pu
    pullup (mem_data[gi]);
  end

  always #5 clk = ~clk;

  led_pwm_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .led_r    (led_r),
    .led_g    (led_g),
    .led_b    (led_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    mem_addr = addr;
    tb_wdata = data;
    tb_oe    = 1'b1;
    mem_we   = 1'b1;
    @(posedge clk);
    #1;
    mem_we = 1'b0;
    tb_oe  = 1'b0;
    $display("wr   %h <= %h", addr, data);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    mem_addr = addr;
    mem_we   = 1'b0;
    #1;
    data = mem_data;
    $display("rd   %h => %h", addr, data);
  endtask

  initial begin
    logic [31:0] rd;
    int hi_r, hi_g, hi_b, hi_r2, bad_st, bad_off;
    logic [1:0] exp_st;

    // Reset, register readback and bus release
    #2 rst = 1'b0;
    mem_addr = A_CTRL;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_leds", {29'b0, led_r, led_g, led_b}, 32'h0);
    check_val("rst_bus_z", mem_data, BUS_Z);
    @(negedge clk);
    rst = 1'b1;

    bus_read(A_CTRL, rd);  check_val("rst_ctrl", rd, 32'h0);
    bus_read(A_PRESC, rd); check_val("rst_presc", rd, 32'h0);
    bus_read(A_DUTY, rd);  check_val("rst_duty", rd, 32'h0);
    bus_read(A_BLINK, rd); check_val("rst_blink", rd, 32'h0);

    @(negedge clk);
    mem_addr = A_CTRL;
    mem_we   = 1'b1;
    #1 check_val("z_on_we", mem_data, BUS_Z);
    mem_we   = 1'b0;
    mem_addr = 32'hffff0020;
    #1 check_val("z_bad_addr", mem_data, BUS_Z);

    bus_write(A_PRESC, 32'hdead1234);
    bus_write(A_DUTY, 32'haabbccdd);
    bus_write(A_BLINK, 32'h12345678);
    bus_write(A_CTRL, 32'hfffffffe);
    bus_write(32'hffff0011, 32'hffffffff);
    bus_write(32'hffff0020, 32'hffffffff);
    bus_read(A_PRESC, rd); check_val("rb_presc", rd, 32'h00001234);
    bus_read(A_DUTY, rd);  check_val("rb_duty", rd, 32'h00bbccdd);
    bus_read(A_BLINK, rd); check_val("rb_blink", rd, 32'h12340078);
    bus_read(A_CTRL, rd);  check_val("rb_ctrl", rd, 32'h00000002);

    // Red at duty 64 with no prescaling
    bus_write(A_CTRL, 32'h0);
    bus_write(A_PRESC, 32'h0);
    bus_write(A_DUTY, 32'h00400000);
    bus_write(A_CTRL, 32'h1);
    mem_addr = A_CTRL;
    hi_r = 0; hi_g = 0; hi_b = 0;
    for (int j = 0; j <= 257; j++) begin
      @(negedge clk);
      if (j == 0) check_val("pwm_still_idle", mem_data, 32'h00000001);
      if (j == 1) begin
        check_val("pwm_state_on", mem_data, 32'h00000101);
        check_val("pwm_led_lat0", {31'b0, led_r}, 32'h0);
      end
      if (j == 2) check_val("pwm_led_lat1", {31'b0, led_r}, 32'h1);
      if (j >= 2) begin
        hi_r += int'(led_r);
        hi_g += int'(led_g);
        hi_b += int'(led_b);
      end
    end
    check_val("pwm_r_high64", hi_r, 32'd64);
    check_val("pwm_g_zero", hi_g, 32'd0);
    check_val("pwm_b_zero", hi_b, 32'd0);

    // Duty change mid-period takes effect only next period
    bus_write(A_CTRL, 32'h0);
    bus_write(A_DUTY, 32'h00100000);
    bus_write(A_CTRL, 32'h1);
    hi_r = 0; hi_r2 = 0;
    for (int j = 0; j <= 513; j++) begin
      @(negedge clk);
      if (j == 40) begin
        mem_addr = A_DUTY;
        tb_wdata = 32'h00f00000;
        tb_oe    = 1'b1;
        mem_we   = 1'b1;
      end else if (j == 41) begin
        mem_we = 1'b0;
        tb_oe  = 1'b0;
      end
      if (j >= 2 && j <= 257) hi_r += int'(led_r);
      if (j >= 258) hi_r2 += int'(led_r);
    end
    check_val("shadow_cur_16", hi_r, 32'd16);
    check_val("shadow_next_240", hi_r2, 32'd240);

    // Blink: ON 1024 clocks, OFF 512 clocks
    bus_write(A_CTRL, 32'h0);
    bus_write(A_PRESC, 32'h1);
    bus_write(A_DUTY, 32'h000000ff);
    bus_write(A_BLINK, 32'h00010000);
    bus_write(A_CTRL, 32'h3);
    mem_addr = A_CTRL;
    hi_b = 0; bad_st = 0; bad_off = 0;
    for (int j = 0; j <= 3072; j++) begin
      @(negedge clk);
      if (j == 0) exp_st = 2'b00;
      else if (j <= 1024) exp_st = 2'b01;
      else if (j <= 1536) exp_st = 2'b10;
      else if (j <= 2560) exp_st = 2'b01;
      else exp_st = 2'b10;
      if (mem_data[9:8] !== exp_st) bad_st++;
      if (j == 1024) check_val("blink_last_on", mem_data, 32'h00000103);
      if (j == 1025) check_val("blink_first_off", mem_data, 32'h00000203);
      if (j == 1536) check_val("blink_last_off", mem_data, 32'h00000203);
      if (j == 1537) check_val("blink_back_on", mem_data, 32'h00000103);
      if (j >= 2 && j <= 1025) hi_b += int'(led_b);
      if (((j >= 1026 && j <= 1537) || j >= 2562) && led_b) bad_off++;
    end
    check_val("blink_state_seq", bad_st, 32'd0);
    check_val("blink_b_on_1020", hi_b, 32'd1020);
    check_val("blink_b_off_zero", bad_off, 32'd0);

    // Disable during ON
    bus_write(A_CTRL, 32'h0);
    mem_addr = A_CTRL;
    @(negedge clk);
    check_val("dis_same_cycle", mem_data, 32'h00000100);
    @(negedge clk);
    check_val("dis_idle", mem_data, 32'h0);
    @(negedge clk);
    check_val("dis_leds", {29'b0, led_r, led_g, led_b}, 32'h0);

    // Asynchronous reset pulse between edges while blinking
    bus_write(A_CTRL, 32'h3);
    mem_addr = A_CTRL;
    repeat (100) @(negedge clk);
    check_val("arst_pre_led_b", {31'b0, led_b}, 32'h1);
    #1 rst = 1'b0;
    #1;
    check_val("arst_leds", {29'b0, led_r, led_g, led_b}, 32'h0);
    check_val("arst_bus_z", mem_data, BUS_Z);
    #1 rst = 1'b1;
    #1 check_val("arst_ctrl_idle", mem_data, 32'h0);
    bus_read(A_PRESC, rd); check_val("arst_presc", rd, 32'h0);
    bus_read(A_DUTY, rd);  check_val("arst_duty", rd, 32'h0);
    bus_read(A_BLINK, rd); check_val("arst_blink", rd, 32'h0);
    repeat (20) @(negedge clk);
    bus_read(A_CTRL, rd);  check_val("arst_stay_idle", rd, 32'h0);
    check_val("arst_leds_stay", {29'b0, led_r, led_g, led_b}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
